pointcloud_triplet_deinterleaver: RTL and testbench

//  Write-side counterpart of the 3:1 one-hot lane mux: accepts a serial byte stream (N,K,M,N,K,M,...)
//  and assembles it into parallel {N,K,M} triplets for the point-cloud datapath.

---
 rtl/pointcloud_pkg.sv | 13 +
 rtl/pointcloud_lane_fsm.sv | 37 +++
 rtl/pointcloud_triplet_deinterleaver.sv | 110 +++++++++++
 tb/tb_pointcloud_triplet_deinterleaver.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pointcloud_pkg.sv
// Shared point-cloud definitions: one-hot lane encodings used by both the 3:1 lane mux
// and the triplet deinterleaver, plus the default lane byte width.
package pointcloud_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [2:0] {
    LANE_N = 3'b001,
    LANE_K = 3'b010,
    LANE_M = 3'b100
  } lane_sel_t;

endpackage : pointcloud_pkg

// File: rtl/pointcloud_lane_fsm.sv
// One-hot lane tracker for the deinterleaver: steps N->K->M->N on each advance, jumps to K on
// a start-of-frame resync, and returns any non one-hot state to N on the next clock.
module pointcloud_lane_fsm
  import pointcloud_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      i_adv,
  input  logic      i_resync,
  output lane_sel_t o_lane_sel
);

  lane_sel_t r_state;
  lane_sel_t w_next;

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= LANE_N;
    else     r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case, so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      LANE_N:  if (i_adv) w_next = LANE_K;
      LANE_K:  if (i_adv) w_next = LANE_M;
      LANE_M:  if (i_adv) w_next = LANE_N;
      default: w_next = LANE_N;
    endcase
    // A resync byte is always stored as N, so the next byte belongs to K.
    if (i_resync) w_next = LANE_K;
  end

  assign o_lane_sel = r_state;

endmodule : pointcloud_lane_fsm

// File: rtl/pointcloud_triplet_deinterleaver.sv
// Serial N,K,M byte stream to parallel {N,K,M} triplets with valid/ready on both sides.
// Define DEINT_SYNC_EN to add the in_sof resync input and the sync_err pulse output.
module pointcloud_triplet_deinterleaver
  import pointcloud_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_n,
  output logic [DATA_W-1:0] out_k,
  output logic [DATA_W-1:0] out_m,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        lane_sel,
  output logic [CNT_W-1:0]  trip_cnt
`ifdef DEINT_SYNC_EN
  ,
  input  logic              in_sof,
  output logic              sync_err
`endif
);

  lane_sel_t         w_lane;
  logic              w_accept;
  logic              w_sof;
  logic              w_store_n;
  logic              w_store_k;
  logic              w_load;
  logic              w_handoff;

  logic [DATA_W-1:0] r_stg_n;
  logic [DATA_W-1:0] r_stg_k;
  logic [DATA_W-1:0] r_out_n;
  logic [DATA_W-1:0] r_out_k;
  logic [DATA_W-1:0] r_out_m;
  logic              r_out_valid;
  logic [CNT_W-1:0]  r_trip_cnt;

  // Staging for N and K is always free; only the M byte needs the output register.
  assign in_ready  = (w_lane == LANE_M) ? (!r_out_valid || out_ready) : 1'b1;
  assign w_accept  = in_valid && in_ready;
  assign w_handoff = r_out_valid && out_ready;

`ifdef DEINT_SYNC_EN
  assign w_sof = w_accept && in_sof;
`else
  assign w_sof = 1'b0;
`endif

  assign w_store_n = w_accept && ((w_lane == LANE_N) || w_sof);
  assign w_store_k = w_accept && (w_lane == LANE_K) && !w_sof;
  assign w_load    = w_accept && (w_lane == LANE_M) && !w_sof;

  pointcloud_lane_fsm u_lane_fsm (
    .clk        (clk),
    .rst        (rst),
    .i_adv      (w_accept && !w_sof),
    .i_resync   (w_sof),
    .o_lane_sel (w_lane)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stg_n     <= '0;
      r_stg_k     <= '0;
      r_out_n     <= '0;
      r_out_k     <= '0;
      r_out_m     <= '0;
      r_out_valid <= 1'b0;
      r_trip_cnt  <= '0;
    end else begin
      if (w_store_n) r_stg_n <= in_data;
      if (w_store_k) r_stg_k <= in_data;
      else if (w_sof) r_stg_k <= '0;
      if (w_load) begin
        r_out_n     <= r_stg_n;
        r_out_k     <= r_stg_k;
        r_out_m     <= in_data;
        r_out_valid <= 1'b1;
      end else if (w_handoff) begin
        r_out_valid <= 1'b0;
      end
      if (w_handoff) r_trip_cnt <= r_trip_cnt + CNT_W'(1);
    end
  end

`ifdef DEINT_SYNC_EN
  logic r_sync_err;

  always_ff @(posedge clk) begin
    if (rst) r_sync_err <= 1'b0;
    else     r_sync_err <= w_sof && (w_lane != LANE_N);
  end

  assign sync_err = r_sync_err;
`endif

  assign out_n     = r_out_n;
  assign out_k     = r_out_k;
  assign out_m     = r_out_m;
  assign out_valid = r_out_valid;
  assign lane_sel  = w_lane;
  assign trip_cnt  = r_trip_cnt;

endmodule : pointcloud_triplet_deinterleaver

// File: tb/tb_pointcloud_triplet_deinterleaver.sv
// Directed bench for pointcloud_triplet_deinterleaver: table-driven handshake vectors plus
// hand-written sequences for streaming, reset mid-triplet, counter wrap and (optionally) resync.
module tb_pointcloud_triplet_deinterleaver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_n, out_k, out_m;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] lane_sel;
  logic [3:0] trip_cnt;
  logic       in_sof = 1'b0;
`ifdef DEINT_SYNC_EN
  logic       sync_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pointcloud_triplet_deinterleaver #(.DATA_W(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_n     (out_n),
    .out_k     (out_k),
    .out_m     (out_m),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lane_sel  (lane_sel),
    .trip_cnt  (trip_cnt)
`ifdef DEINT_SYNC_EN
    ,
    .in_sof    (in_sof),
    .sync_err  (sync_err)
`endif
  );

  typedef struct {
    logic [7:0]  d;
    logic        v;
    logic        r;
    logic        e_rdy;
    logic [2:0]  e_lane;
    logic        e_ov;
    logic [23:0] e_nkm;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_sof = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Presents one byte until accepted (bounded), returns at posedge+1 with in_valid low.
  task automatic push(input logic [7:0] d, input logic sof);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    in_sof   = sof;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("push_accept_bound", 32'(n < 20), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  logic       exp_ov;
  logic       hand;
  logic [3:0] exp_cnt;
  logic [7:0] b;

  initial begin
    // Test 1 (v0..v3) then test 2 (v4..v11), one clock per record.
    vecs[0]  = '{8'h11, 1'b1, 1'b1, 1'b1, 3'b010, 1'b0, 24'h000000, 4'd0};
    vecs[1]  = '{8'h22, 1'b1, 1'b1, 1'b1, 3'b100, 1'b0, 24'h000000, 4'd0};
    vecs[2]  = '{8'h33, 1'b1, 1'b1, 1'b1, 3'b001, 1'b1, 24'h112233, 4'd0};
    vecs[3]  = '{8'h00, 1'b0, 1'b1, 1'b1, 3'b001, 1'b0, 24'h112233, 4'd1};
    vecs[4]  = '{8'h01, 1'b1, 1'b0, 1'b1, 3'b010, 1'b0, 24'h112233, 4'd1};
    vecs[5]  = '{8'h02, 1'b1, 1'b0, 1'b1, 3'b100, 1'b0, 24'h112233, 4'd1};
    vecs[6]  = '{8'h03, 1'b1, 1'b0, 1'b1, 3'b001, 1'b1, 24'h010203, 4'd1};
    vecs[7]  = '{8'h04, 1'b1, 1'b0, 1'b1, 3'b010, 1'b1, 24'h010203, 4'd1};
    vecs[8]  = '{8'h05, 1'b1, 1'b0, 1'b1, 3'b100, 1'b1, 24'h010203, 4'd1};
    vecs[9]  = '{8'h06, 1'b1, 1'b0, 1'b0, 3'b100, 1'b1, 24'h010203, 4'd1};
    vecs[10] = '{8'h06, 1'b1, 1'b1, 1'b1, 3'b001, 1'b1, 24'h040506, 4'd2};
    vecs[11] = '{8'h00, 1'b0, 1'b1, 1'b1, 3'b001, 1'b0, 24'h040506, 4'd3};

    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;

    check("reset_lane_sel", 32'(lane_sel), 32'h1);
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_outputs", {8'h0, out_n, out_k, out_m}, 32'h0);
    check("reset_trip_cnt", 32'(trip_cnt), 32'h0);

    for (int i = 0; i < 12; i++) begin
      in_data   = vecs[i].d;
      in_valid  = vecs[i].v;
      out_ready = vecs[i].r;
      @(negedge clk);
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
      @(posedge clk); #1;
      check($sformatf("vec%0d_lane_sel", i), 32'(lane_sel), 32'(vecs[i].e_lane));
      check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      check($sformatf("vec%0d_nkm", i), {8'h0, out_n, out_k, out_m}, {8'h0, vecs[i].e_nkm});
      check($sformatf("vec%0d_trip_cnt", i), 32'(trip_cnt), 32'(vecs[i].e_cnt));
    end
    in_valid = 1'b0;

    // Test 3: back-to-back triplets with out_ready held high.
    exp_ov  = 1'b0;
    exp_cnt = 4'd3;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      b = 8'h40 + 8'(i);
      in_data  = b;
      in_valid = 1'b1;
      @(negedge clk);
      check("stream_in_ready", 32'(in_ready), 32'h1);
      hand = exp_ov;
      @(posedge clk); #1;
      exp_cnt = exp_cnt + 4'(hand);
      exp_ov  = (i % 3 == 2);
      check("stream_out_valid", 32'(out_valid), 32'(exp_ov));
      check("stream_trip_cnt", 32'(trip_cnt), 32'(exp_cnt));
      if (i % 3 == 2)
        check("stream_nkm", {8'h0, out_n, out_k, out_m}, {8'h0, b - 8'd2, b - 8'd1, b});
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 4'(exp_ov);
    check("stream_final_cnt", 32'(trip_cnt), 32'(exp_cnt));

    // Test 4: reset with a pending output triplet and a partial AA,BB triplet.
    out_ready = 1'b0;
    push(8'h71, 1'b0);
    push(8'h72, 1'b0);
    push(8'h73, 1'b0);
    push(8'hAA, 1'b0);
    push(8'hBB, 1'b0);
    check("pre_rst_pending", 32'(out_valid), 32'h1);
    check("pre_rst_lane", 32'(lane_sel), 32'h4);
    do_reset();
    check("rst_mid_lane", 32'(lane_sel), 32'h1);
    check("rst_mid_out_valid", 32'(out_valid), 32'h0);
    check("rst_mid_cnt", 32'(trip_cnt), 32'h0);
    out_ready = 1'b1;
    push(8'hC1, 1'b0);
    push(8'hC2, 1'b0);
    push(8'hC3, 1'b0);
    check("clean_out_valid", 32'(out_valid), 32'h1);
    check("clean_nkm", {8'h0, out_n, out_k, out_m}, 32'h00C1C2C3);
    @(posedge clk); #1;
    check("clean_cnt", 32'(trip_cnt), 32'h1);

    // Test 5: 17 handoffs on a 4-bit counter wrap to 1.
    do_reset();
    out_ready = 1'b1;
    for (int t = 0; t < 17; t++) begin
      push(8'(3 * t), 1'b0);
      push(8'(3 * t + 1), 1'b0);
      push(8'(3 * t + 2), 1'b0);
    end
    @(posedge clk); #1;
    check("wrap_trip_cnt", 32'(trip_cnt), 32'h1);
    check("wrap_out_valid", 32'(out_valid), 32'h0);

`ifdef DEINT_SYNC_EN
    // Test 6: start-of-frame arriving in lane M resyncs the partial triplet.
    do_reset();
    out_ready = 1'b1;
    push(8'h10, 1'b1);
    check("sof_n_no_err", 32'(sync_err), 32'h0);
    push(8'h20, 1'b0);
    push(8'h30, 1'b1);
    check("resync_err_pulse", 32'(sync_err), 32'h1);
    check("resync_lane", 32'(lane_sel), 32'h2);
    check("resync_no_output", 32'(out_valid), 32'h0);
    @(posedge clk); #1;
    check("resync_err_clear", 32'(sync_err), 32'h0);
    push(8'h40, 1'b0);
    push(8'h50, 1'b0);
    check("resync_out_valid", 32'(out_valid), 32'h1);
    check("resync_nkm", {8'h0, out_n, out_k, out_m}, 32'h00304050);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pointcloud_triplet_deinterleaver
